// File: rtl/ahbl_master.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into
// NONSEQ transfers with a two-slot (address/data phase) pipeline.
module ahbl_master #(
    parameter logic [31:0] ID          = 32'h0000_0A00,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Alignment/size legality of a command; only the low address bits matter.
    function automatic logic cmd_illegal(input logic [1:0] addr_lo, input logic [2:0] size);
        case (size)
            3'd0:    cmd_illegal = 1'b0;
            3'd1:    cmd_illegal = addr_lo[0];
            3'd2:    cmd_illegal = (addr_lo != 2'b00);
            default: cmd_illegal = 1'b1;
        endcase
    endfunction

    logic        ap_valid_r;
    logic [31:0] ap_addr_r;
    logic [2:0]  ap_size_r;
    logic        ap_write_r;
    logic [31:0] ap_wdata_r;
    logic        ap_err_r;
    logic [1:0]  htrans_r;

    logic        dp_valid_r;
    logic        dp_write_r;
    logic [31:0] dp_wdata_r;
    logic        dp_err_r;

    logic        rsp_valid_r;
    logic        rsp_write_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;

    logic        cmd_ready_s;
    logic        accept_s;
    logic        cmd_err_s;
    logic        unused_id_s;

    // The ready path from HREADY is deliberately combinational so a full
    // address slot can be refilled on the same edge it drains.
    assign cmd_ready_s = ~ap_valid_r | HREADY;
    assign accept_s    = cmd_valid & cmd_ready_s;
    assign cmd_err_s   = CHECK_ALIGN & cmd_illegal(cmd_addr[1:0], cmd_size);
    assign unused_id_s = ^ID;

    // Address-phase slot; address/size/direction hold their last value when empty.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_r <= 1'b0;
            ap_addr_r  <= 32'h0000_0000;
            ap_size_r  <= 3'd0;
            ap_write_r <= 1'b0;
            ap_wdata_r <= 32'h0000_0000;
            ap_err_r   <= 1'b0;
            htrans_r   <= HTRANS_IDLE;
        end else if (accept_s) begin
            ap_valid_r <= 1'b1;
            ap_addr_r  <= cmd_addr;
            ap_size_r  <= cmd_size;
            ap_write_r <= cmd_write;
            ap_wdata_r <= cmd_wdata;
            ap_err_r   <= cmd_err_s;
            htrans_r   <= cmd_err_s ? HTRANS_IDLE : HTRANS_NONSEQ;
        end else if (HREADY) begin
            ap_valid_r <= 1'b0;
            htrans_r   <= HTRANS_IDLE;
        end
    end

    // Data-phase slot; advances only when the fabric completes the phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_wdata_r <= 32'h0000_0000;
            dp_err_r   <= 1'b0;
        end else if (HREADY) begin
            dp_valid_r <= ap_valid_r;
            dp_write_r <= ap_write_r;
            dp_wdata_r <= ap_wdata_r;
            dp_err_r   <= ap_err_r;
        end
    end

    // One-cycle response pulse when the data phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else if (HREADY && dp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_write_r <= dp_write_r;
            rsp_err_r   <= dp_err_r;
            rsp_rdata_r <= (!dp_write_r && !dp_err_r) ? HRDATA : 32'h0000_0000;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign HADDR     = ap_addr_r;
    assign HTRANS    = htrans_r;
    assign HSIZE     = ap_size_r;
    assign HWRITE    = ap_write_r;
    assign HWDATA    = dp_wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_write = rsp_write_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ahbl_master.sv
// Bench for ahbl_master: 8 KB RAM slave with a wait-stated read window at
// 0x100-0x1FF, directed command stream, queue-based response scoreboard.
module tb_ahbl_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    ahbl_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] mem [0:2047];
    logic        s_valid;
    logic        s_write;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    logic [1:0]  ws_cnt;
    logic        s_wait;

    function automatic logic [3:0] lanes(input logic [1:0] a, input logic [2:0] sz);
        case (sz)
            3'd0:    lanes = 4'b0001 << a;
            3'd1:    lanes = a[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    assign s_wait = s_valid && !s_write && (s_addr[12:8] == 5'd1);
    assign HREADY = !(s_wait && ws_cnt != 2'd2);
    assign HRDATA = s_valid ? mem[s_addr[12:2]] : 32'h0000_0000;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_addr  <= 32'h0;
            s_size  <= 3'd0;
            ws_cnt  <= 2'd0;
        end else if (HREADY) begin
            if (s_valid && s_write) begin
                for (int b = 0; b < 4; b++)
                    if (lanes(s_addr[1:0], s_size)[b])
                        mem[s_addr[12:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
            s_valid <= (HTRANS == 2'b10);
            s_addr  <= HADDR;
            s_write <= HWRITE;
            s_size  <= HSIZE;
            ws_cnt  <= 2'd0;
        end else begin
            ws_cnt <= ws_cnt + 2'd1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected rsp: got rsp_valid=1 at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, " rsp_write"}, {31'd0, rsp_write}, {31'd0, e.wr});
                chk({e.tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                chk({e.tag, " rsp_rdata"}, rsp_rdata, e.rdata);
                chk({e.tag, " latency"}, cyc - e.acc, e.lat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int lat, input bit push);
        bit   ok;
        logic rdy;
        exp_t e;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_size  = size;
        cmd_wdata = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 rdy = cmd_ready;
            @(negedge HCLK);
            if (rdy) ok = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s accept: no cmd_ready within 50 cycles, required acceptance", tag);
        end else begin
            chk({tag, " HTRANS"}, {30'd0, HTRANS}, exp_err ? 32'd0 : 32'd2);
            chk({tag, " HSIZE"}, {29'd0, HSIZE}, {29'd0, size});
            chk({tag, " HWRITE"}, {31'd0, HWRITE}, {31'd0, wr});
            if (!exp_err) chk({tag, " HADDR"}, HADDR, addr);
            if (push) begin
                e.tag = tag; e.wr = wr; e.err = exp_err; e.rdata = exp_rdata;
                e.acc = cyc; e.lat = lat;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_write = 1'b0;
        cmd_size  = 3'd0;
        cmd_wdata = 32'h0;
        idle(3);
        chk("reset HTRANS", {30'd0, HTRANS}, 32'd0);
        chk("reset HADDR", HADDR, 32'd0);
        chk("reset HWDATA", HWDATA, 32'd0);
        chk("reset HSIZE", {29'd0, HSIZE}, 32'd0);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk("idle HTRANS", {30'd0, HTRANS}, 32'd0);
            chk("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);
            chk("idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end

        // word write then read-back of the same location
        send("wr10", 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1);
        send("rd10", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
        chk("wr10 HWDATA", HWDATA, 32'hDEAD_BEEF);
        idle(6);

        // back-to-back mixed sizes with lane-placed write data
        send("wr20", 32'h20, 1'b1, 3'd2, 32'h5A5A_5A5A, 1'b0, 32'h0, 2, 1'b1);
        send("wrb21", 32'h21, 1'b1, 3'd0, 32'h0000_AA00, 1'b0, 32'h0, 2, 1'b1);
        send("wrh22", 32'h22, 1'b1, 3'd1, 32'h1234_0000, 1'b0, 32'h0, 2, 1'b1);
        send("rd20", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1234_AA5A, 2, 1'b1);
        idle(6);

        // two wait states on the read of 0x104, next read held in the address slot
        send("wr104", 32'h104, 1'b1, 3'd2, 32'h0BAD_F00D, 1'b0, 32'h0, 2, 1'b1);
        send("rd104", 32'h104, 1'b0, 3'd2, 32'h5555_AAAA, 1'b0, 32'h0BAD_F00D, 4, 1'b1);
        send("rd10b", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1);
        chk("ws1 HREADY", {31'd0, HREADY}, 32'd0);
        chk("ws1 cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("ws1 HWDATA", HWDATA, 32'h5555_AAAA);
        @(negedge HCLK);
        chk("ws2 HREADY", {31'd0, HREADY}, 32'd0);
        chk("ws2 cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("ws2 HTRANS", {30'd0, HTRANS}, 32'd2);
        chk("ws2 HADDR", HADDR, 32'h10);
        chk("ws2 HWDATA", HWDATA, 32'h5555_AAAA);
        @(negedge HCLK);
        chk("ws3 HREADY", {31'd0, HREADY}, 32'd1);
        chk("ws3 cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("ws3 HWDATA", HWDATA, 32'h5555_AAAA);
        idle(6);

        // illegal commands travel as IDLE bubbles and keep response order
        send("rdok1", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
        send("rdmis", 32'h02, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0, 2, 1'b1);
        send("rdok2", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1234_AA5A, 2, 1'b1);
        send("wrhmis", 32'h11, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0, 2, 1'b1);
        send("wrsz3", 32'h00, 1'b1, 3'd3, 32'hFFFF_FFFF, 1'b1, 32'h0, 2, 1'b1);
        idle(6);
        send("rdchk", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
        idle(6);

        // asynchronous reset in the middle of a wait-stated data phase
        send("rdabort", 32'h104, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        @(negedge HCLK);
        chk("abort HREADY", {31'd0, HREADY}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("abort HTRANS", {30'd0, HTRANS}, 32'd0);
        chk("abort HADDR", HADDR, 32'd0);
        chk("abort HWDATA", HWDATA, 32'd0);
        chk("abort HSIZE", {29'd0, HSIZE}, 32'd0);
        chk("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        send("rdpost", 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1234_AA5A, 2, 1'b1);
        idle(10);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
